radix3_input_sequencer: RTL and testbench
=========================================

Name: radix3_input_sequencer

Overview:
- Source-side feeder for the radix-3 butterfly pipeline.
- Accepts a serial stream of complex samples under a valid/ready handshake and groups consecutive samples into (a, b, c) triples.
- Presents each triple as a 3-lane parallel complex word to the butterfly pipeline inputs, with frame-boundary tracking and zero-padding of short tail groups.

Parameters:
- W, 32, bit width of each real/imaginary component
- GW, 8, width of group index counter
- PIPE_LAT, 4, downstream pipeline latency in cycles (used only with R3SEQ_LAT_TRACK_EN)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous active-high reset
- s_valid  in  1  input sample valid
- s_ready  out  1  input sample accepted when s_valid&&s_ready
- s_re  in  W  sample real part
- s_img  in  W  sample imaginary part
- s_last  in  1  sample is last of frame
- o_valid  out  1  triple valid
- o_ready  in  1  consumer accepts triple when o_valid&&o_ready
- a_re, a_img, b_re, b_img, c_re, c_img  out  W each  triple lanes (a = oldest sample)
- o_last  out  1  triple is last group of frame
- o_pad  out  2  number of zero-padded lanes in triple (0, 1 or 2)
- grp_idx  out  GW  index of triple within frame

Behaviour:
- Single clock domain (clk). Reset is synchronous, active-high (rst).
- Reset values: all lane outputs 0, o_valid=0, o_last=0, o_pad=0, grp_idx=0. FSM resets to LOAD_A. Internal group counter resets to 0.
- Reset mid-frame discards any partially collected samples and any held triple. Nothing is emitted for them.
- FSM states: LOAD_A, LOAD_B, LOAD_C. The state advances on each accepted sample.
  - LOAD_A → LOAD_B → LOAD_C → LOAD_A.
  - Accepted s_last in any state returns to LOAD_A.
- Collection registers hold lanes a and b. Lane c comes directly from the accepted input.
- Triple completion:
  - Accept in LOAD_C completes a triple.
  - Accept with s_last in LOAD_A completes a triple with b=c=0, o_pad=2.
  - Accept with s_last in LOAD_B completes a triple with c=0, o_pad=1.
  - Accept in LOAD_C with s_last completes a triple with o_pad=0, o_last=1.
- Output register loads on the cycle after the completing accept (latency 1 from the last sample to o_valid).
- Output-register contents and sideband:
  - grp_idx = value of the internal counter at completion.
  - The counter increments per completed triple and wraps at 2^GW.
  - The counter clears to 0 after a completed triple with o_last=1.
- o_valid stays asserted and all outputs stay stable until o_valid&&o_ready.
- Back-to-back: if the held triple is accepted in the same cycle a new triple completes, the new triple loads in the next cycle with no bubble.
- s_ready = !(o_valid && !o_ready && completing_state).
  - completing_state means LOAD_C, or s_last presented.
  - A completing sample stalls only while an unaccepted triple is held.
  - Non-completing samples are always accepted.
- Sustained throughput: one sample per cycle when o_ready=1.
- s_valid=0 cycles are tolerated in any state. Partial contents are held indefinitely.
- Arithmetic: none. Data passes bit-exact. Pad lanes are exactly 0.

Optional Feature:
- Macro R3SEQ_LAT_TRACK_EN.
- When defined, adds outputs res_valid (1), res_last (1) and res_grp (GW).
  - A PIPE_LAT-deep shift register carries {o_valid&&o_ready, o_last, grp_idx}.
  - res_* is therefore aligned with butterfly-pipeline results PIPE_LAT cycles after acceptance.
  - The shift register is cleared by rst.
- When undefined, these ports and the shift register do not exist. Core behaviour is identical.

Decomposition:
- Shared package r3_pkg holds:
  - FSM state encoding (LOAD_A=0, LOAD_B=1, LOAD_C=2)
  - pad-count constants
  - default W/GW values
- One natural sub-module: r3_valid_delay, the PIPE_LAT shift register for the optional tracking path.

Test Plan:
- Reset then 6 samples (1+1j … 6+6j), o_ready=1, s_last on sample 6:
  - triple 1 = (1+1j, 2+2j, 3+3j), grp_idx=0, o_last=0
  - triple 2 = (4+4j, 5+5j, 6+6j), grp_idx=1, o_last=1, o_pad=0
- Frame of 4 samples with s_last on sample 4:
  - second triple = (4+4j, 0, 0), o_pad=2, o_last=1
  - next frame starts at grp_idx=0
- Hold o_ready=0 while 6 samples stream:
  - first triple held stable
  - s_ready drops when sample 6 is presented
  - release o_ready → second triple appears the next cycle; no sample lost or duplicated
- Assert rst after 2 samples of a frame, then send 3 new samples:
  - only one triple emitted, containing the post-reset samples, grp_idx=0
- GW=2, 5 continuous frames of 3 samples without s_last across groups, i.e. 15 samples with s_last only at the end:
  - grp_idx sequence 0, 1, 2, 3, 0
- With R3SEQ_LAT_TRACK_EN, PIPE_LAT=4:
  - res_valid pulses exactly 4 cycles after each o_valid&&o_ready
  - res_last/res_grp match the accepted triple's o_last/grp_idx

Source files
------------

// File: rtl/r3_pkg.sv
// Shared definitions for the radix-3 input sequencer: FSM encoding,
// pad-count constants and default widths.
package r3_pkg;

    localparam int R3_W_DEFAULT  = 32;
    localparam int R3_GW_DEFAULT = 8;

    typedef enum logic [1:0] {
        LOAD_A = 2'd0,
        LOAD_B = 2'd1,
        LOAD_C = 2'd2
    } r3_state_e;

    localparam logic [1:0] PAD_NONE = 2'd0;
    localparam logic [1:0] PAD_ONE  = 2'd1;
    localparam logic [1:0] PAD_TWO  = 2'd2;

endpackage

// File: rtl/r3_valid_delay.sv
// DEPTH-stage shift register carrying {valid, last, grp} so that sideband
// lines up with butterfly-pipeline results DEPTH cycles after acceptance.
module r3_valid_delay #(
    parameter int DEPTH = 4,
    parameter int GW    = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic          in_last,
    input  logic [GW-1:0] in_grp,
    output logic          res_valid,
    output logic          res_last,
    output logic [GW-1:0] res_grp
);

    logic          vld_q [DEPTH];
    logic          vld_d [DEPTH];
    logic          lst_q [DEPTH];
    logic          lst_d [DEPTH];
    logic [GW-1:0] grp_q [DEPTH];
    logic [GW-1:0] grp_d [DEPTH];

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
        if (gi == 0) begin : g_head
            always_comb begin
                vld_d[gi] = in_valid;
                lst_d[gi] = in_last;
                grp_d[gi] = in_grp;
            end
        end else begin : g_tail
            always_comb begin
                vld_d[gi] = vld_q[gi-1];
                lst_d[gi] = lst_q[gi-1];
                grp_d[gi] = grp_q[gi-1];
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                vld_q[gi] <= 1'b0;
                lst_q[gi] <= 1'b0;
                grp_q[gi] <= '0;
            end else begin
                vld_q[gi] <= vld_d[gi];
                lst_q[gi] <= lst_d[gi];
                grp_q[gi] <= grp_d[gi];
            end
        end
    end

    assign res_valid = vld_q[DEPTH-1];
    assign res_last  = lst_q[DEPTH-1];
    assign res_grp   = grp_q[DEPTH-1];

endmodule

// File: rtl/radix3_input_sequencer.sv
// Groups a serial complex sample stream into (a, b, c) triples for the radix-3
// butterfly, zero-padding short frame tails. Optional R3SEQ_LAT_TRACK_EN adds res_* tracking.
module radix3_input_sequencer
    import r3_pkg::*;
#(
    parameter int W        = R3_W_DEFAULT,
    parameter int GW       = R3_GW_DEFAULT,
    parameter int PIPE_LAT = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic [W-1:0]  s_re,
    input  logic [W-1:0]  s_img,
    input  logic          s_last,
    output logic          o_valid,
    input  logic          o_ready,
    output logic [W-1:0]  a_re,
    output logic [W-1:0]  a_img,
    output logic [W-1:0]  b_re,
    output logic [W-1:0]  b_img,
    output logic [W-1:0]  c_re,
    output logic [W-1:0]  c_img,
    output logic          o_last,
    output logic [1:0]    o_pad,
    output logic [GW-1:0] grp_idx
`ifdef R3SEQ_LAT_TRACK_EN
    ,
    output logic          res_valid,
    output logic          res_last,
    output logic [GW-1:0] res_grp
`endif
);

    r3_state_e     state_q, state_d;
    logic [W-1:0]  col_a_re_q, col_a_re_d, col_a_img_q, col_a_img_d;
    logic [W-1:0]  col_b_re_q, col_b_re_d, col_b_img_q, col_b_img_d;
    logic [GW-1:0] grp_cnt_q, grp_cnt_d;

    logic          o_valid_q, o_valid_d;
    logic [W-1:0]  a_re_q, a_re_d, a_img_q, a_img_d;
    logic [W-1:0]  b_re_q, b_re_d, b_img_q, b_img_d;
    logic [W-1:0]  c_re_q, c_re_d, c_img_q, c_img_d;
    logic          o_last_q, o_last_d;
    logic [1:0]    o_pad_q, o_pad_d;
    logic [GW-1:0] grp_idx_q, grp_idx_d;

    logic completing;
    logic s_fire;
    logic complete;

    // Only a sample that would finish a triple must wait for the output slot.
    assign completing = (state_q == LOAD_C) || s_last;
    assign s_ready    = !(o_valid_q && !o_ready && completing);
    assign s_fire     = s_valid && s_ready;
    assign complete   = s_fire && completing;

    always_comb begin
        state_d     = state_q;
        col_a_re_d  = col_a_re_q;
        col_a_img_d = col_a_img_q;
        col_b_re_d  = col_b_re_q;
        col_b_img_d = col_b_img_q;
        grp_cnt_d   = grp_cnt_q;
        o_valid_d   = o_valid_q;
        a_re_d      = a_re_q;
        a_img_d     = a_img_q;
        b_re_d      = b_re_q;
        b_img_d     = b_img_q;
        c_re_d      = c_re_q;
        c_img_d     = c_img_q;
        o_last_d    = o_last_q;
        o_pad_d     = o_pad_q;
        grp_idx_d   = grp_idx_q;

        if (s_fire) begin
            case (state_q)
                LOAD_A: begin
                    col_a_re_d  = s_re;
                    col_a_img_d = s_img;
                    state_d     = s_last ? LOAD_A : LOAD_B;
                end
                LOAD_B: begin
                    col_b_re_d  = s_re;
                    col_b_img_d = s_img;
                    state_d     = s_last ? LOAD_A : LOAD_C;
                end
                default: state_d = LOAD_A;
            endcase
        end

        if (o_valid_q && o_ready) begin
            o_valid_d = 1'b0;
        end

        // A new triple overrides the drain above, giving bubble-free back-to-back.
        if (complete) begin
            o_valid_d = 1'b1;
            o_last_d  = s_last;
            grp_idx_d = grp_cnt_q;
            grp_cnt_d = s_last ? '0 : grp_cnt_q + 1'b1;
            case (state_q)
                LOAD_A: begin
                    a_re_d  = s_re;
                    a_img_d = s_img;
                    b_re_d  = '0;
                    b_img_d = '0;
                    c_re_d  = '0;
                    c_img_d = '0;
                    o_pad_d = PAD_TWO;
                end
                LOAD_B: begin
                    a_re_d  = col_a_re_q;
                    a_img_d = col_a_img_q;
                    b_re_d  = s_re;
                    b_img_d = s_img;
                    c_re_d  = '0;
                    c_img_d = '0;
                    o_pad_d = PAD_ONE;
                end
                default: begin
                    a_re_d  = col_a_re_q;
                    a_img_d = col_a_img_q;
                    b_re_d  = col_b_re_q;
                    b_img_d = col_b_img_q;
                    c_re_d  = s_re;
                    c_img_d = s_img;
                    o_pad_d = PAD_NONE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= LOAD_A;
            col_a_re_q  <= '0;
            col_a_img_q <= '0;
            col_b_re_q  <= '0;
            col_b_img_q <= '0;
            grp_cnt_q   <= '0;
            o_valid_q   <= 1'b0;
            a_re_q      <= '0;
            a_img_q     <= '0;
            b_re_q      <= '0;
            b_img_q     <= '0;
            c_re_q      <= '0;
            c_img_q     <= '0;
            o_last_q    <= 1'b0;
            o_pad_q     <= PAD_NONE;
            grp_idx_q   <= '0;
        end else begin
            state_q     <= state_d;
            col_a_re_q  <= col_a_re_d;
            col_a_img_q <= col_a_img_d;
            col_b_re_q  <= col_b_re_d;
            col_b_img_q <= col_b_img_d;
            grp_cnt_q   <= grp_cnt_d;
            o_valid_q   <= o_valid_d;
            a_re_q      <= a_re_d;
            a_img_q     <= a_img_d;
            b_re_q      <= b_re_d;
            b_img_q     <= b_img_d;
            c_re_q      <= c_re_d;
            c_img_q     <= c_img_d;
            o_last_q    <= o_last_d;
            o_pad_q     <= o_pad_d;
            grp_idx_q   <= grp_idx_d;
        end
    end

    assign o_valid = o_valid_q;
    assign a_re    = a_re_q;
    assign a_img   = a_img_q;
    assign b_re    = b_re_q;
    assign b_img   = b_img_q;
    assign c_re    = c_re_q;
    assign c_img   = c_img_q;
    assign o_last  = o_last_q;
    assign o_pad   = o_pad_q;
    assign grp_idx = grp_idx_q;

`ifdef R3SEQ_LAT_TRACK_EN
    r3_valid_delay #(
        .DEPTH (PIPE_LAT),
        .GW    (GW)
    ) u_lat_track (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (o_valid_q && o_ready),
        .in_last   (o_last_q),
        .in_grp    (grp_idx_q),
        .res_valid (res_valid),
        .res_last  (res_last),
        .res_grp   (res_grp)
    );
`else
    // Tracking path compiled out; PIPE_LAT is kept so both builds share one parameter list.
    if (PIPE_LAT < 1) begin : g_lat_unused
    end
`endif

endmodule

// File: tb/tb_radix3_input_sequencer.sv
// Self-checking bench: directed test-plan scenarios plus randomized traffic
// checked against a queue-based triple-grouping model.
module tb_radix3_input_sequencer;

    localparam int W        = 32;
    localparam int GW       = 2;
    localparam int PIPE_LAT = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [W-1:0]  s_re = '0;
    logic [W-1:0]  s_img = '0;
    logic          s_last = 1'b0;
    logic          o_valid;
    logic          o_ready = 1'b0;
    logic [W-1:0]  a_re, a_img, b_re, b_img, c_re, c_img;
    logic          o_last;
    logic [1:0]    o_pad;
    logic [GW-1:0] grp_idx;
`ifdef R3SEQ_LAT_TRACK_EN
    logic          res_valid;
    logic          res_last;
    logic [GW-1:0] res_grp;
`endif

    always #5 clk = ~clk;

    radix3_input_sequencer #(
        .W        (W),
        .GW       (GW),
        .PIPE_LAT (PIPE_LAT)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_re    (s_re),
        .s_img   (s_img),
        .s_last  (s_last),
        .o_valid (o_valid),
        .o_ready (o_ready),
        .a_re    (a_re),
        .a_img   (a_img),
        .b_re    (b_re),
        .b_img   (b_img),
        .c_re    (c_re),
        .c_img   (c_img),
        .o_last  (o_last),
        .o_pad   (o_pad),
        .grp_idx (grp_idx)
`ifdef R3SEQ_LAT_TRACK_EN
        ,
        .res_valid (res_valid),
        .res_last  (res_last),
        .res_grp   (res_grp)
`endif
    );

    typedef struct packed {
        logic [W-1:0]  a_re;
        logic [W-1:0]  a_img;
        logic [W-1:0]  b_re;
        logic [W-1:0]  b_img;
        logic [W-1:0]  c_re;
        logic [W-1:0]  c_img;
        logic          last;
        logic [1:0]    pad;
        logic [GW-1:0] grp;
    } trip_t;

    int n_checks = 0;
    int n_fail   = 0;

    trip_t          exp_q[$];
    trip_t          got_q[$];
    logic [2*W-1:0] buf_q[$];
    int             m_grp = 0;

    function automatic trip_t mk(input int a, input int b, input int c,
                                 input bit last, input int pad, input int grp);
        trip_t t;
        t.a_re  = W'(a);
        t.a_img = W'(a);
        t.b_re  = W'(b);
        t.b_img = W'(b);
        t.c_re  = W'(c);
        t.c_img = W'(c);
        t.last  = last;
        t.pad   = 2'(pad);
        t.grp   = GW'(grp);
        return t;
    endfunction

    function automatic trip_t cur_out();
        trip_t t;
        t.a_re  = a_re;
        t.a_img = a_img;
        t.b_re  = b_re;
        t.b_img = b_img;
        t.c_re  = c_re;
        t.c_img = c_img;
        t.last  = o_last;
        t.pad   = o_pad;
        t.grp   = grp_idx;
        return t;
    endfunction

`ifdef R3SEQ_LAT_TRACK_EN
    logic          hist_v [PIPE_LAT+1];
    logic          hist_l [PIPE_LAT+1];
    logic [GW-1:0] hist_g [PIPE_LAT+1];
`endif

    // Reference model: samples are grouped in threes or cut short by s_last.
    always @(negedge clk) begin
        bit    exp_ready;
        trip_t t;
        if (rst) begin
            exp_q.delete();
            buf_q.delete();
            m_grp = 0;
`ifdef R3SEQ_LAT_TRACK_EN
            for (int i = 0; i <= PIPE_LAT; i++) begin
                hist_v[i] = 1'b0;
                hist_l[i] = 1'b0;
                hist_g[i] = '0;
            end
`endif
        end else begin
            n_checks++;
            if (o_valid !== (exp_q.size() != 0)) begin
                n_fail++;
                $display("FAIL o_valid: got %b expected %b", o_valid, exp_q.size() != 0);
            end
            exp_ready = !((exp_q.size() != 0) && !o_ready && ((buf_q.size() == 2) || s_last));
            n_checks++;
            if (s_ready !== exp_ready) begin
                n_fail++;
                $display("FAIL s_ready: got %b expected %b", s_ready, exp_ready);
            end
            if (o_valid && exp_q.size() != 0) begin
                n_checks++;
                if (cur_out() !== exp_q[0]) begin
                    n_fail++;
                    $display("FAIL triple: got %h expected %h", cur_out(), exp_q[0]);
                end
            end
`ifdef R3SEQ_LAT_TRACK_EN
            for (int i = PIPE_LAT; i > 0; i--) begin
                hist_v[i] = hist_v[i-1];
                hist_l[i] = hist_l[i-1];
                hist_g[i] = hist_g[i-1];
            end
            hist_v[0] = o_valid && o_ready;
            hist_l[0] = o_last;
            hist_g[0] = grp_idx;
            n_checks++;
            if (res_valid !== hist_v[PIPE_LAT]) begin
                n_fail++;
                $display("FAIL res_valid: got %b expected %b", res_valid, hist_v[PIPE_LAT]);
            end
            if (hist_v[PIPE_LAT]) begin
                n_checks++;
                if (res_last !== hist_l[PIPE_LAT] || res_grp !== hist_g[PIPE_LAT]) begin
                    n_fail++;
                    $display("FAIL res_sideband: got last=%b grp=%0d expected last=%b grp=%0d",
                             res_last, res_grp, hist_l[PIPE_LAT], hist_g[PIPE_LAT]);
                end
            end
`endif
            if (o_valid && o_ready) begin
                got_q.push_back(cur_out());
                if (exp_q.size() != 0) void'(exp_q.pop_front());
            end
            if (s_valid && s_ready) begin
                buf_q.push_back({s_re, s_img});
                if (buf_q.size() == 3 || s_last) begin
                    t = '0;
                    t.a_re  = buf_q[0][2*W-1:W];
                    t.a_img = buf_q[0][W-1:0];
                    if (buf_q.size() >= 2) begin
                        t.b_re  = buf_q[1][2*W-1:W];
                        t.b_img = buf_q[1][W-1:0];
                    end
                    if (buf_q.size() == 3) begin
                        t.c_re  = buf_q[2][2*W-1:W];
                        t.c_img = buf_q[2][W-1:0];
                    end
                    t.pad  = 2'(3 - buf_q.size());
                    t.last = s_last;
                    t.grp  = GW'(m_grp);
                    m_grp  = s_last ? 0 : (m_grp + 1) % (1 << GW);
                    exp_q.push_back(t);
                    buf_q.delete();
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [W-1:0] re, input logic [W-1:0] im, input logic last);
        bit acc;
        int cyc;
        s_valid = 1'b1;
        s_re    = re;
        s_img   = im;
        s_last  = last;
        acc     = 1'b0;
        cyc     = 0;
        while (!acc && cyc < 100) begin
            @(negedge clk);
            acc = s_ready;
            tick();
            cyc++;
        end
        n_checks++;
        if (!acc) begin
            n_fail++;
            $display("FAIL send_timeout: sample %0d not accepted after %0d cycles", re, cyc);
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        s_valid = 1'b0;
        o_ready = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (o_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_o_valid: got %b expected 0", o_valid);
        end
        n_checks++;
        if (cur_out() !== trip_t'(0)) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h expected 0", cur_out());
        end
        n_checks++;
        if (s_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_s_ready: got %b expected 1", s_ready);
        end
        tick();
    endtask

    task automatic test_basic();
        o_ready = 1'b1;
        got_q.delete();
        for (int i = 1; i <= 6; i++) send(W'(i), W'(i), i == 6);
        repeat (3) tick();
        n_checks++;
        if (got_q.size() != 2) begin
            n_fail++;
            $display("FAIL basic_count: got %0d triples expected 2", got_q.size());
        end else begin
            n_checks++;
            if (got_q[0] !== mk(1, 2, 3, 0, 0, 0)) begin
                n_fail++;
                $display("FAIL basic_t0: got %h expected %h", got_q[0], mk(1, 2, 3, 0, 0, 0));
            end
            n_checks++;
            if (got_q[1] !== mk(4, 5, 6, 1, 0, 1)) begin
                n_fail++;
                $display("FAIL basic_t1: got %h expected %h", got_q[1], mk(4, 5, 6, 1, 0, 1));
            end
        end
    endtask

    task automatic test_short_frame();
        o_ready = 1'b1;
        got_q.delete();
        for (int i = 1; i <= 4; i++) send(W'(i), W'(i), i == 4);
        for (int i = 5; i <= 7; i++) send(W'(i), W'(i), i == 7);
        repeat (3) tick();
        n_checks++;
        if (got_q.size() != 3) begin
            n_fail++;
            $display("FAIL short_count: got %0d triples expected 3", got_q.size());
        end else begin
            n_checks++;
            if (got_q[1] !== mk(4, 0, 0, 1, 2, 1)) begin
                n_fail++;
                $display("FAIL short_pad2: got %h expected %h", got_q[1], mk(4, 0, 0, 1, 2, 1));
            end
            n_checks++;
            if (got_q[2] !== mk(5, 6, 7, 1, 0, 0)) begin
                n_fail++;
                $display("FAIL short_next_frame: got %h expected %h", got_q[2], mk(5, 6, 7, 1, 0, 0));
            end
        end
        got_q.delete();
        send(W'(8), W'(8), 1'b0);
        send(W'(9), W'(9), 1'b1);
        repeat (3) tick();
        n_checks++;
        if (got_q.size() != 1 || got_q[0] !== mk(8, 9, 0, 1, 1, 0)) begin
            n_fail++;
            $display("FAIL short_pad1: got n=%0d %h expected %h", got_q.size(),
                     got_q.size() != 0 ? got_q[0] : trip_t'(0), mk(8, 9, 0, 1, 1, 0));
        end
    endtask

    task automatic test_backpressure();
        o_ready = 1'b0;
        got_q.delete();
        for (int i = 1; i <= 5; i++) send(W'(i), W'(i), 1'b0);
        s_valid = 1'b1;
        s_re    = W'(6);
        s_img   = W'(6);
        s_last  = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_checks++;
            if (s_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_stall: got s_ready=%b expected 0", s_ready);
            end
            n_checks++;
            if (o_valid !== 1'b1 || cur_out() !== mk(1, 2, 3, 0, 0, 0)) begin
                n_fail++;
                $display("FAIL bp_hold: got v=%b %h expected %h", o_valid, cur_out(), mk(1, 2, 3, 0, 0, 0));
            end
            tick();
        end
        o_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if (s_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_release: got s_ready=%b expected 1", s_ready);
        end
        tick();
        s_valid = 1'b0;
        s_last  = 1'b0;
        @(negedge clk);
        n_checks++;
        if (o_valid !== 1'b1 || cur_out() !== mk(4, 5, 6, 1, 0, 1)) begin
            n_fail++;
            $display("FAIL bp_next: got v=%b %h expected %h", o_valid, cur_out(), mk(4, 5, 6, 1, 0, 1));
        end
        repeat (2) tick();
        n_checks++;
        if (got_q.size() != 2) begin
            n_fail++;
            $display("FAIL bp_count: got %0d triples expected 2", got_q.size());
        end
    endtask

    task automatic test_mid_reset();
        o_ready = 1'b1;
        for (int i = 1; i <= 5; i++) send(W'(i), W'(i), 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        got_q.delete();
        for (int i = 7; i <= 9; i++) send(W'(i), W'(i), i == 9);
        repeat (3) tick();
        n_checks++;
        if (got_q.size() != 1 || got_q[0] !== mk(7, 8, 9, 1, 0, 0)) begin
            n_fail++;
            $display("FAIL mid_reset: got n=%0d %h expected %h", got_q.size(),
                     got_q.size() != 0 ? got_q[0] : trip_t'(0), mk(7, 8, 9, 1, 0, 0));
        end
    endtask

    task automatic test_grp_wrap();
        o_ready = 1'b1;
        got_q.delete();
        for (int i = 1; i <= 15; i++) send(W'(i), W'(i), i == 15);
        repeat (3) tick();
        n_checks++;
        if (got_q.size() != 5) begin
            n_fail++;
            $display("FAIL wrap_count: got %0d triples expected 5", got_q.size());
        end else begin
            for (int k = 0; k < 5; k++) begin
                n_checks++;
                if (got_q[k] !== mk(3*k+1, 3*k+2, 3*k+3, k == 4, 0, k % 4)) begin
                    n_fail++;
                    $display("FAIL wrap_t%0d: got %h expected %h", k, got_q[k],
                             mk(3*k+1, 3*k+2, 3*k+3, k == 4, 0, k % 4));
                end
            end
        end
    endtask

    task automatic test_random();
        got_q.delete();
        for (int i = 0; i < 1500; i++) begin
            rst     = ($urandom_range(0, 299) == 0);
            s_valid = ($urandom_range(0, 3) != 0);
            s_re    = $urandom;
            s_img   = $urandom;
            s_last  = ($urandom_range(0, 4) == 0);
            o_ready = ($urandom_range(0, 2) != 0);
            tick();
        end
        rst     = 1'b0;
        s_valid = 1'b0;
        s_last  = 1'b0;
        o_ready = 1'b1;
        repeat (4) tick();
        n_checks++;
        if (got_q.size() < 50) begin
            n_fail++;
            $display("FAIL random_traffic: got %0d triples expected at least 50", got_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_short_frame();
        test_backpressure();
        test_mid_reset();
        test_grp_wrap();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
